// File: rtl/serial_result_rx_if.sv
// Handshake/bus bundle between the serial result receiver and its neighbours.
// master: the side driving the serial stream and consuming the FIFO words.
// slave:  the receiver itself.
interface serial_result_rx_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             en_i;
  logic             in_c;
  logic             clr_i;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic [CW-1:0]    count_o;
  logic             ovf_o;
  logic             ferr_o;

  modport master (
    output en_i, in_c, clr_i, ready_i,
    input  data_o, valid_o, count_o, ovf_o, ferr_o
  );

  modport slave (
    input  en_i, in_c, clr_i, ready_i,
    output data_o, valid_o, count_o, ovf_o, ferr_o
  );
endinterface

// File: rtl/serial_result_rx.sv
// Serial-to-parallel receiver for the serial adder result stream.
// Frames start with a one-cycle en_i strobe on the MSB; completed words are
// buffered in a first-word-fall-through FIFO drained by valid/ready.
// Sticky flags report dropped words (ovf_o) and restarted frames (ferr_o).
module serial_result_rx #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  serial_result_rx_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] msb_load;
  logic             push;
  logic             ferr_set;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count, count_n;
  logic             valid_q;
  logic             ovf_q, ferr_q;
  logic             pop, full, push_ok, ovf_set;

  // The MSB of sreg is shifted out as the word completes and is never read.
  logic             sreg_msb_unused;
  assign sreg_msb_unused = sreg[WIDTH-1];

  assign shifted  = {sreg[WIDTH-2:0], bus.in_c};
  assign msb_load = {{(WIDTH-1){1'b0}}, bus.in_c};

  // Receive FSM state, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bcnt  <= '0;
      sreg  <= '0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      sreg  <= sreg_n;
    end
  end

  // Next-state logic: frame start, shifting, completion and framing restart.
  always_comb begin
    state_n  = state;
    bcnt_n   = bcnt;
    sreg_n   = sreg;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.en_i) begin
          sreg_n  = msb_load;
          bcnt_n  = BW'(1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en_i) begin
          // A strobe mid-word abandons the partial word and restarts on this bit.
          ferr_set = 1'b1;
          sreg_n   = msb_load;
          bcnt_n   = BW'(1);
        end else begin
          sreg_n = shifted;
          if (bcnt == BW'(WIDTH - 1)) begin
            push    = 1'b1;
            bcnt_n  = '0;
            state_n = IDLE;
          end else begin
            bcnt_n = bcnt + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop     = valid_q & bus.ready_i;
  assign full    = (count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  // Occupancy update from accepted push and pop.
  always_comb begin
    count_n = count;
    unique case ({push_ok, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // FIFO pointers, occupancy, valid and sticky flags (set wins over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count   <= count_n;
      valid_q <= (count_n != '0);
      ovf_q   <= ovf_set  | (ovf_q  & ~bus.clr_i);
      ferr_q  <= ferr_set | (ferr_q & ~bus.clr_i);
    end
  end

  // FIFO storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shifted;
  end

  assign bus.data_o  = valid_q ? mem[rd_ptr] : '0;
  assign bus.valid_o = valid_q;
  assign bus.count_o = count;
  assign bus.ovf_o   = ovf_q;
  assign bus.ferr_o  = ferr_q;
endmodule

// File: tb/tb_serial_result_rx.sv
// Self-checking bench for serial_result_rx (WIDTH=3, DEPTH=4).
// Expected words are queued as frames are driven and compared as they pop.
module tb_serial_result_rx;
  localparam int unsigned W  = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D) + 1;

  logic clk;
  logic rst_n;

  serial_result_rx_if #(.WIDTH(W), .DEPTH(D)) bus ();

  serial_result_rx #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [W-1:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Pop monitor: a pop happens at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else                   check("pop_data", 32'(bus.data_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit accept,
                           input bit pop_last, input bit clr_last);
    for (int unsigned k = 0; k < W; k++) begin
      bus.en_i = (k == 0);
      bus.in_c = w[W-1-k];
      if (k == W - 1) begin
        if (accept)   exp_q.push_back(w);
        if (pop_last) bus.ready_i = 1'b1;
        if (clr_last) bus.clr_i   = 1'b1;
      end
      tick();
    end
    bus.en_i    = 1'b0;
    bus.in_c    = 1'b1;
    bus.ready_i = 1'b0;
    bus.clr_i   = 1'b0;
  endtask

  task automatic drain();
    bus.ready_i = 1'b1;
    for (int unsigned k = 0; k < 3 * D; k++) begin
      if (!bus.valid_o) break;
      tick();
    end
    bus.ready_i = 1'b0;
    check("drain_valid", 32'(bus.valid_o), 32'd0);
    check("drain_count", 32'(bus.count_o), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_data"},  32'(bus.data_o),  32'd0);
    check({tag, "_count"}, 32'(bus.count_o), 32'd0);
    check({tag, "_ovf"},   32'(bus.ovf_o),   32'd0);
    check({tag, "_ferr"},  32'(bus.ferr_o),  32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en_i    = 1'b0;
    bus.in_c    = 1'b1;
    bus.clr_i   = 1'b0;
    bus.ready_i = 1'b0;
    repeat (2) tick();
    check_zero_outputs("reset");
    #2 rst_n = 1'b1;
    tick();

    // Single word 101, held with ready low, then popped.
    send_word(3'b101, 1'b1, 1'b0, 1'b0);
    check("single_valid", 32'(bus.valid_o), 32'd1);
    check("single_data",  32'(bus.data_o),  32'h5);
    check("single_count", 32'(bus.count_o), 32'd1);
    tick();
    check("single_hold",  32'(bus.data_o),  32'h5);
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    check("single_pop_valid", 32'(bus.valid_o), 32'd0);
    check("single_pop_data",  32'(bus.data_o),  32'd0);

    // Fill and overflow: fifth back-to-back word is dropped.
    for (int unsigned i = 1; i <= 5; i++)
      send_word(W'(i), (i <= D), 1'b0, 1'b0);
    check("fill_count", 32'(bus.count_o), 32'(D));
    check("fill_ovf",   32'(bus.ovf_o),   32'd1);
    check("fill_ferr",  32'(bus.ferr_o),  32'd0);
    drain();
    pulse_clr();
    check("clr_ovf", 32'(bus.ovf_o), 32'd0);

    // Framing error: frame restarted after two bits.
    bus.en_i = 1'b1; bus.in_c = 1'b1; tick();
    bus.en_i = 1'b0; bus.in_c = 1'b0; tick();
    check("ferr_pre", 32'(bus.ferr_o), 32'd0);
    bus.en_i = 1'b1; bus.in_c = 1'b0; tick();
    check("ferr_set", 32'(bus.ferr_o), 32'd1);
    bus.en_i = 1'b0; bus.in_c = 1'b1; tick();
    exp_q.push_back(3'b011);
    bus.in_c = 1'b1; tick();
    bus.in_c = 1'b1;
    check("ferr_count", 32'(bus.count_o), 32'd1);
    check("ferr_data",  32'(bus.data_o),  32'h3);
    check("ferr_ovf",   32'(bus.ovf_o),   32'd0);
    check("ferr_sticky", 32'(bus.ferr_o), 32'd1);
    drain();
    pulse_clr();
    check("clr_ferr", 32'(bus.ferr_o), 32'd0);

    // Full FIFO: pop coincides with the fifth word completing.
    send_word(3'b110, 1'b1, 1'b0, 1'b0);
    send_word(3'b111, 1'b1, 1'b0, 1'b0);
    send_word(3'b000, 1'b1, 1'b0, 1'b0);
    send_word(3'b001, 1'b1, 1'b0, 1'b0);
    check("full_count", 32'(bus.count_o), 32'(D));
    send_word(3'b010, 1'b1, 1'b1, 1'b0);
    check("pp_count", 32'(bus.count_o), 32'(D));
    check("pp_ovf",   32'(bus.ovf_o),   32'd0);
    check("pp_head",  32'(bus.data_o),  32'h7);
    drain();

    // Overflow coinciding with clr: set wins.
    for (int unsigned i = 0; i < D; i++)
      send_word(W'(i + 3), 1'b1, 1'b0, 1'b0);
    send_word(3'b111, 1'b0, 1'b0, 1'b0);
    check("ovf2_set", 32'(bus.ovf_o), 32'd1);
    pulse_clr();
    check("ovf2_clr", 32'(bus.ovf_o), 32'd0);
    send_word(3'b110, 1'b0, 1'b0, 1'b1);
    check("ovf_clr_same", 32'(bus.ovf_o), 32'd1);
    check("ovf_clr_count", 32'(bus.count_o), 32'(D));
    drain();
    pulse_clr();

    // Asynchronous reset mid-frame with two words buffered.
    send_word(3'b100, 1'b1, 1'b0, 1'b0);
    send_word(3'b010, 1'b1, 1'b0, 1'b0);
    check("pre_rst_count", 32'(bus.count_o), 32'd2);
    bus.en_i = 1'b1; bus.in_c = 1'b1; tick();
    bus.en_i = 1'b0; bus.in_c = 1'b1; tick();
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_zero_outputs("async_rst");
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_count", 32'(bus.count_o), 32'd0);
    send_word(3'b011, 1'b1, 1'b0, 1'b0);
    check("post_rst_count1", 32'(bus.count_o), 32'd1);
    check("post_rst_data",   32'(bus.data_o),  32'h3);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
